stack_controller: RTL and testbench

- Sequences the 1024x8 single-port SRAM (8-bit bidirectional data bus, 10-bit address, RWS=1 write / RWS=0 read, CS active-high) as a LIFO stack.
- Accepts one-cycle Push/Pop requests from the user side, keeps the stack pointer, and generates glitch-free setup/strobe/hold sequences on the RAM pins.
- Sits between the stack front-end and the RAM in the Stack datapath.

---
 rtl/stack_controller.sv | 156 +++++++++++++++
 tb/tb_stack_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_controller.sv
// rtl/stack_controller.sv - LIFO stack sequencer for a 1024x8 single-port SRAM
module stack_controller #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Push,
  input  logic              Pop,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              Done,
  output logic              Error,
  output logic              Busy,
  output logic              Full,
  output logic              Empty,
  output logic [ADDR_W:0]   Count,
  inout  wire  [DATA_W-1:0] RamIO,
  output logic [ADDR_W-1:0] RamAddress,
  output logic              RamRWS,
  output logic              RamCS
);

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_PULSE,
    W_HOLD,
    R_SETUP,
    R_PULSE
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   sp_q, sp_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rws_q, rws_d;
  logic              cs_q, cs_d;
  logic              drive_q, drive_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              full, empty;

  assign full  = (sp_q == DEPTH_L);
  assign empty = (sp_q == '0);

  // Next-state decode; RAM pin values are computed one cycle ahead so every pin is a flop
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    addr_d  = addr_q;
    rws_d   = rws_q;
    cs_d    = 1'b0;
    drive_d = drive_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        rws_d   = 1'b0;
        drive_d = 1'b0;
        if (Push && Pop) begin
          err_d = 1'b1;
        end else if (Push && full) begin
          err_d = 1'b1;
        end else if (Pop && empty) begin
          err_d = 1'b1;
        end else if (Push) begin
          wdata_d = DataIn;
          addr_d  = sp_q[ADDR_W-1:0];
          rws_d   = 1'b1;
          drive_d = 1'b1;
          state_d = W_SETUP;
        end else if (Pop) begin
          // Low bits minus one is correct even when SP == DEPTH (low bits are zero)
          addr_d  = sp_q[ADDR_W-1:0] - 1'b1;
          state_d = R_SETUP;
        end
      end
      W_SETUP: begin
        cs_d    = 1'b1;
        state_d = W_PULSE;
      end
      W_PULSE: begin
        state_d = W_HOLD;
      end
      W_HOLD: begin
        sp_d    = sp_q + 1'b1;
        rws_d   = 1'b0;
        drive_d = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      R_SETUP: begin
        cs_d    = 1'b1;
        state_d = R_PULSE;
      end
      R_PULSE: begin
        dout_d  = RamIO;
        sp_d    = sp_q - 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        rws_d   = 1'b0;
        drive_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset that also aborts any RAM access
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      sp_q    <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      addr_q  <= '0;
      rws_q   <= 1'b0;
      cs_q    <= 1'b0;
      drive_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      addr_q  <= addr_d;
      rws_q   <= rws_d;
      cs_q    <= cs_d;
      drive_q <= drive_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign RamIO      = drive_q ? wdata_q : {DATA_W{1'bz}};
  assign RamAddress = addr_q;
  assign RamRWS     = rws_q;
  assign RamCS      = cs_q;
  assign DataOut    = dout_q;
  assign Done       = done_q;
  assign Error      = err_q;
  assign Busy       = (state_q != IDLE);
  assign Full       = full;
  assign Empty      = empty;
  assign Count      = sp_q;

endmodule

// File: tb/tb_stack_controller.sv
// tb/tb_stack_controller.sv - self-checking bench for stack_controller
module tb_stack_controller;

  logic        Clk = 1'b0;
  logic        Reset, Push, Pop;
  logic [7:0]  DataIn, DataOut;
  logic        Done, Error, Busy, Full, Empty;
  logic [10:0] Count;
  wire  [7:0]  ram_io;
  logic [9:0]  RamAddress;
  logic        RamRWS, RamCS;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [0:1023];
  int         wr_count = 0;
  int         done_count = 0;
  int         err_count = 0;
  logic [9:0] last_wr_addr = '0;
  logic       prev_rws = 1'b0;

  stack_controller dut (
    .Clk(Clk), .Reset(Reset), .Push(Push), .Pop(Pop), .DataIn(DataIn),
    .DataOut(DataOut), .Done(Done), .Error(Error), .Busy(Busy), .Full(Full),
    .Empty(Empty), .Count(Count), .RamIO(ram_io), .RamAddress(RamAddress),
    .RamRWS(RamRWS), .RamCS(RamCS)
  );

  always #5 Clk = ~Clk;

  // Released bus reads as all ones
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (ram_io[g]);
  end

  // SRAM model: drives during read strobe, captures on write strobe
  assign ram_io = (RamCS && !RamRWS) ? mem[RamAddress] : 8'hzz;

  always @(posedge Clk) begin
    if (RamCS && RamRWS) begin
      mem[RamAddress] <= ram_io;
      wr_count        <= wr_count + 1;
      last_wr_addr    <= RamAddress;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Protocol monitor: RWS steady under CS, bus released whenever nobody may drive it
  always @(negedge Clk) begin
    if (Done) done_count++;
    if (Error) err_count++;
    if (RamCS) chk("rws_stable_under_cs", {31'd0, RamRWS}, {31'd0, prev_rws});
    if (RamRWS === 1'b0 && RamCS === 1'b0) chk("bus_released", {24'd0, ram_io}, 32'hFF);
    prev_rws = RamRWS;
  end

  // Issue one request for one cycle (call at a negedge) and observe a 5-cycle window
  task automatic run_op(input logic p, input logic q, input logic [7:0] d,
                        output int done_lat, output int err_n, output int busy_n, output int cs_n);
    done_lat = 0; err_n = 0; busy_n = 0; cs_n = 0;
    Push = p; Pop = q; DataIn = d;
    @(negedge Clk);
    Push = 1'b0; Pop = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (Done && done_lat == 0) done_lat = i;
      if (Error) err_n++;
      if (Busy) busy_n++;
      if (RamCS) cs_n++;
      @(negedge Clk);
    end
  endtask

  typedef struct {
    logic       p;
    logic       q;
    logic [7:0] d;
    int         done_lat;
    int         err_n;
    int         busy_n;
    logic [7:0] dout;
    int         count;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dl, en, bn, cn, wbase, dbase, ebase, bad;
    vecs[0] = '{1'b0, 1'b1, 8'h00, 0, 1, 0, 8'h00, 0};
    vecs[1] = '{1'b1, 1'b0, 8'hA5, 4, 0, 3, 8'h00, 1};
    vecs[2] = '{1'b1, 1'b0, 8'h3C, 4, 0, 3, 8'h00, 2};
    vecs[3] = '{1'b1, 1'b1, 8'hFF, 0, 1, 0, 8'h00, 2};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 3, 0, 2, 8'h3C, 1};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 3, 0, 2, 8'hA5, 0};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 0, 1, 0, 8'hA5, 0};
    vecs[7] = '{1'b1, 1'b0, 8'h5A, 4, 0, 3, 8'hA5, 1};
    vecs[8] = '{1'b0, 1'b1, 8'h00, 3, 0, 2, 8'h5A, 0};

    Reset = 1'b1; Push = 1'b0; Pop = 1'b0; DataIn = 8'h00;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    chk("rst_empty", {31'd0, Empty}, 32'd1);
    chk("rst_full", {31'd0, Full}, 32'd0);
    chk("rst_count", {21'd0, Count}, 32'd0);
    chk("rst_cs", {31'd0, RamCS}, 32'd0);
    chk("rst_rws", {31'd0, RamRWS}, 32'd0);
    chk("rst_bus", {24'd0, ram_io}, 32'hFF);
    chk("rst_dout", {24'd0, DataOut}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);

    for (int v = 0; v < 9; v++) begin
      wbase = wr_count;
      run_op(vecs[v].p, vecs[v].q, vecs[v].d, dl, en, bn, cn);
      chk($sformatf("v%0d_done_lat", v), dl, vecs[v].done_lat);
      chk($sformatf("v%0d_err", v), en, vecs[v].err_n);
      chk($sformatf("v%0d_busy", v), bn, vecs[v].busy_n);
      chk($sformatf("v%0d_cs", v), cn, (vecs[v].busy_n > 0) ? 1 : 0);
      chk($sformatf("v%0d_dout", v), {24'd0, DataOut}, {24'd0, vecs[v].dout});
      chk($sformatf("v%0d_count", v), {21'd0, Count}, vecs[v].count);
      chk($sformatf("v%0d_empty", v), {31'd0, Empty}, (vecs[v].count == 0) ? 1 : 0);
      if (vecs[v].p && !vecs[v].q) begin
        chk($sformatf("v%0d_wr_addr", v), {22'd0, last_wr_addr}, vecs[v].count - 1);
        chk($sformatf("v%0d_wr_n", v), wr_count - wbase, 1);
      end
    end

    // Cycle-exact push followed by a pop accepted in the Done cycle
    Push = 1'b1; DataIn = 8'h77;
    @(negedge Clk); Push = 1'b0;
    chk("w_setup_addr", {22'd0, RamAddress}, 32'd0);
    chk("w_setup_rws", {31'd0, RamRWS}, 32'd1);
    chk("w_setup_cs", {31'd0, RamCS}, 32'd0);
    chk("w_setup_bus", {24'd0, ram_io}, 32'h77);
    @(negedge Clk);
    chk("w_pulse_cs", {31'd0, RamCS}, 32'd1);
    chk("w_pulse_rws", {31'd0, RamRWS}, 32'd1);
    chk("w_pulse_bus", {24'd0, ram_io}, 32'h77);
    @(negedge Clk);
    chk("w_hold_cs", {31'd0, RamCS}, 32'd0);
    chk("w_hold_rws", {31'd0, RamRWS}, 32'd1);
    chk("w_hold_bus", {24'd0, ram_io}, 32'h77);
    @(negedge Clk);
    chk("w_done", {31'd0, Done}, 32'd1);
    chk("w_done_rws", {31'd0, RamRWS}, 32'd0);
    chk("w_done_count", {21'd0, Count}, 32'd1);
    chk("w_done_busy", {31'd0, Busy}, 32'd0);
    Pop = 1'b1;
    @(negedge Clk); Pop = 1'b0;
    chk("r_setup_busy", {31'd0, Busy}, 32'd1);
    chk("r_setup_addr", {22'd0, RamAddress}, 32'd0);
    chk("r_setup_cs", {31'd0, RamCS}, 32'd0);
    @(negedge Clk);
    chk("r_pulse_cs", {31'd0, RamCS}, 32'd1);
    chk("r_pulse_bus", {24'd0, ram_io}, 32'h77);
    @(negedge Clk);
    chk("r_done", {31'd0, Done}, 32'd1);
    chk("r_done_cs", {31'd0, RamCS}, 32'd0);
    chk("r_done_dout", {24'd0, DataOut}, 32'h77);
    chk("r_done_empty", {31'd0, Empty}, 32'd1);
    repeat (2) @(negedge Clk);

    // Push held high through the whole write: exactly one write and one Done
    wbase = wr_count; dbase = done_count; ebase = err_count;
    Push = 1'b1; DataIn = 8'h11;
    repeat (4) @(negedge Clk);
    Push = 1'b0;
    repeat (3) @(negedge Clk);
    chk("held_writes", wr_count - wbase, 1);
    chk("held_dones", done_count - dbase, 1);
    chk("held_errors", err_count - ebase, 0);
    chk("held_count", {21'd0, Count}, 32'd1);
    run_op(1'b0, 1'b1, 8'h00, dl, en, bn, cn);
    chk("held_pop_dout", {24'd0, DataOut}, 32'h11);

    // Reset during W_PULSE aborts the write
    Push = 1'b1; DataIn = 8'h99;
    @(negedge Clk); Push = 1'b0;
    @(negedge Clk);
    chk("abort_pulse_cs", {31'd0, RamCS}, 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("abort_cs", {31'd0, RamCS}, 32'd0);
    chk("abort_bus", {24'd0, ram_io}, 32'hFF);
    chk("abort_count", {21'd0, Count}, 32'd0);
    chk("abort_empty", {31'd0, Empty}, 32'd1);
    chk("abort_done", {31'd0, Done}, 32'd0);
    dbase = done_count;
    repeat (4) @(negedge Clk);
    chk("abort_no_done", done_count - dbase, 0);

    // Fill all 1024 entries, then overflow
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      run_op(1'b1, 1'b0, i[7:0], dl, en, bn, cn);
      if (dl != 4 || en != 0) bad++;
    end
    chk("fill_all_done", bad, 0);
    chk("fill_last_addr", {22'd0, last_wr_addr}, 32'd1023);
    chk("fill_full", {31'd0, Full}, 32'd1);
    chk("fill_count", {21'd0, Count}, 32'd1024);
    run_op(1'b1, 1'b0, 8'hEE, dl, en, bn, cn);
    chk("ovf_err", en, 1);
    chk("ovf_cs", cn, 0);
    chk("ovf_busy", bn, 0);
    chk("ovf_count", {21'd0, Count}, 32'd1024);
    run_op(1'b0, 1'b1, 8'h00, dl, en, bn, cn);
    chk("top_pop_dout", {24'd0, DataOut}, 32'hFF);
    chk("top_pop_count", {21'd0, Count}, 32'd1023);
    chk("top_pop_full", {31'd0, Full}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
